// File: rtl/line_fill_ctrl.sv
// Purpose : line-fill and write-through responder between an L1 cache line port and a narrow memory port.
// Latency : line read BEATS+1 cycles with single-cycle acks; write-through posted; forwarded read 1 cycle.
// Backpr. : beat requests held until m_ack; b_rd held by cache until b_dv; b_wr while busy is dropped.
//
// Build option: define LFC_RD_FWD_EN to keep the last written line and answer matching reads from it.
//
// Ports:
//   clk, clr_n        clock and synchronous active-low reset
//   b_addr            line address from cache (offset bits inside the line ignored)
//   b_rd / b_wr       line read request (level) / line write request (1-cycle pulse)
//   b_wdata           write line, sampled the cycle after the b_wr pulse
//   b_rdata / b_dv    assembled read line / one-cycle read-valid pulse
//   m_addr            beat address (line base + beat offset), 0 when no request is up
//   m_rd / m_wr       beat read / write request, held until m_ack
//   m_wdata / m_rdata beat write data / beat read data (valid with m_ack)
//   m_ack             beat complete
//   busy              high whenever the FSM is not idle
//   wr_drop           sticky flag: a b_wr arrived when it could not be accepted
module line_fill_ctrl #(
  parameter int LINE_W = 1024,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 16
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [63:0]       b_addr,
  input  logic              b_rd,
  input  logic              b_wr,
  input  logic [LINE_W-1:0] b_wdata,
  output logic [LINE_W-1:0] b_rdata,
  output logic              b_dv,
  output logic [63:0]       m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [BEAT_W-1:0] m_wdata,
  input  logic [BEAT_W-1:0] m_rdata,
  input  logic              m_ack,
  output logic              busy,
  output logic              wr_drop
);

  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_W / 8);   // byte offset bits inside a line
  localparam int BOFF_W = $clog2(BEAT_W / 8);   // byte offset bits inside a beat
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_BEAT = 3'd1,
    RD_DONE = 3'd2,
    WR_CAP  = 3'd3,
    WR_BEAT = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] beat_cnt;
  logic [63:0]      rd_line;     // line base of the read in flight
  logic [63:0]      wr_line;     // line base of the buffered write
  logic [LINE_W-1:0] wbuf;

  logic             last_beat;
  logic             rd_start;
  logic             drop_set;
  logic [63:0]      beat_off;

  // Offset bits of the cache address are meaningless for a line request.
  logic             unused_addr_bits;
  assign unused_addr_bits = ^b_addr[OFF_W-1:0];

  function automatic logic [63:0] line_of(input logic [63:0] a);
    line_of = {a[63:OFF_W], {OFF_W{1'b0}}};
  endfunction

`ifdef LFC_RD_FWD_EN
  // wbuf/wr_line stay valid after the drain so a later read of the same
  // line can be answered without touching memory.
  logic wvalid;
  logic fwd_hit;
  assign fwd_hit = wvalid && (line_of(b_addr) == wr_line);
`endif

  assign last_beat = (beat_cnt == LAST_BEAT);
  assign beat_off  = 64'(beat_cnt) << BOFF_W;

  // ---------------------------------------------------------------------
  // Next state and per-state outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    m_rd      = 1'b0;
    m_wr      = 1'b0;
    b_dv      = 1'b0;
    rd_start  = 1'b0;
    drop_set  = 1'b0;
    case (state)
      IDLE: begin
        // A write pulse cannot be replayed by the cache, so it wins over a
        // read, which the cache keeps holding until served.
        if (b_wr) begin
          state_nxt = WR_CAP;
        end else if (b_rd) begin
`ifdef LFC_RD_FWD_EN
          if (fwd_hit) begin
            state_nxt = RD_DONE;
          end else begin
            rd_start  = 1'b1;
            state_nxt = RD_BEAT;
          end
`else
          rd_start  = 1'b1;
          state_nxt = RD_BEAT;
`endif
        end
      end
      RD_BEAT: begin
        m_rd     = 1'b1;
        drop_set = b_wr;
        if (m_ack && last_beat) state_nxt = RD_DONE;
      end
      RD_DONE: begin
        b_dv = 1'b1;
        // Miss-write issued alongside the fill completion is accepted here.
        state_nxt = b_wr ? WR_CAP : IDLE;
      end
      WR_CAP: begin
        drop_set  = b_wr;
        state_nxt = WR_BEAT;
      end
      WR_BEAT: begin
        m_wr     = 1'b1;
        drop_set = b_wr;
        if (m_ack && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Address/data are forced to zero when no beat request is up, so they
  // only change while idle or between beats.
  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    if (m_rd) begin
      m_addr = rd_line + beat_off;
    end else if (m_wr) begin
      m_addr  = wr_line + beat_off;
      m_wdata = wbuf[BEAT_W*beat_cnt +: BEAT_W];
    end
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      rd_line  <= '0;
      wr_line  <= '0;
      wbuf     <= '0;
      b_rdata  <= '0;
      wr_drop  <= 1'b0;
`ifdef LFC_RD_FWD_EN
      wvalid   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;

      if (drop_set) wr_drop <= 1'b1;

      case (state)
        IDLE: begin
          if (rd_start) begin
            rd_line  <= line_of(b_addr);
            beat_cnt <= '0;
          end
`ifdef LFC_RD_FWD_EN
          if (!b_wr && b_rd && fwd_hit) b_rdata <= wbuf;
`endif
        end
        RD_BEAT: begin
          if (m_ack) begin
            b_rdata[BEAT_W*beat_cnt +: BEAT_W] <= m_rdata;
            // Counter returns to zero only as the FSM leaves the beat state.
            beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
          end
        end
        WR_CAP: begin
          wbuf     <= b_wdata;
          wr_line  <= line_of(b_addr);
          beat_cnt <= '0;
`ifdef LFC_RD_FWD_EN
          wvalid   <= 1'b1;
`endif
        end
        WR_BEAT: begin
          if (m_ack) beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// Purpose : directed self-checking bench for line_fill_ctrl (reads, delayed acks, writes, drops, reset).
// Latency : read latency measured from the cycle b_rd is first presented to the b_dv cycle.
// Backpr. : memory model acks each beat ack_delay cycles after the request rises.
module tb_line_fill_ctrl;

  localparam int LINE_W = 1024;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 16;

  logic              clk = 1'b0;
  logic              clr_n;
  logic [63:0]       b_addr;
  logic              b_rd;
  logic              b_wr;
  logic [LINE_W-1:0] b_wdata;
  logic [LINE_W-1:0] b_rdata;
  logic              b_dv;
  logic [63:0]       m_addr;
  logic              m_rd;
  logic              m_wr;
  logic [BEAT_W-1:0] m_wdata;
  logic [BEAT_W-1:0] m_rdata;
  logic              m_ack;
  logic              busy;
  logic              wr_drop;

  always #5 clk = ~clk;

  line_fill_ctrl #(.LINE_W(LINE_W), .BEAT_W(BEAT_W), .BEATS(BEATS)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .b_addr  (b_addr),
    .b_rd    (b_rd),
    .b_wr    (b_wr),
    .b_wdata (b_wdata),
    .b_rdata (b_rdata),
    .b_dv    (b_dv),
    .m_addr  (m_addr),
    .m_rd    (m_rd),
    .m_wr    (m_wr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .busy    (busy),
    .wr_drop (wr_drop)
  );

  // ---------------- memory model ----------------
  int unsigned ack_delay = 0;
  int unsigned wait_cnt  = 0;
  int          rd_beats  = 0;   // read acks since time zero
  int          rd_base   = 0;   // m_rdata = beat index of the current read
  int          cyc       = 0;

  assign m_ack   = (m_rd || m_wr) && (wait_cnt == ack_delay);
  assign m_rdata = 64'(rd_beats - rd_base);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!(m_rd || m_wr) || m_ack) wait_cnt <= 0;
    else                          wait_cnt <= wait_cnt + 1;
    if (m_rd && m_ack) rd_beats <= rd_beats + 1;
  end

  // ---------------- monitor (mid-cycle) ----------------
  logic [63:0] rd_log [0:511];
  logic [63:0] wa_log [0:511];
  logic [63:0] wd_log [0:511];
  int          rd_n = 0, wr_n = 0, dv_n = 0, both_n = 0, unstable_n = 0;
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [63:0] prev_addr = '0, prev_wdata = '0;

  always @(negedge clk) begin
    if (m_rd && m_ack) begin
      if (rd_n < 512) rd_log[rd_n] = m_addr;
      rd_n++;
    end
    if (m_wr && m_ack) begin
      if (wr_n < 512) begin
        wa_log[wr_n] = m_addr;
        wd_log[wr_n] = m_wdata;
      end
      wr_n++;
    end
    if (b_dv) dv_n++;
    if (m_rd && m_wr) both_n++;
    if (prev_req && !prev_ack && (m_rd || m_wr) &&
        (m_addr != prev_addr || m_wdata != prev_wdata)) unstable_n++;
    prev_req   = m_rd || m_wr;
    prev_ack   = m_ack;
    prev_addr  = m_addr;
    prev_wdata = m_wdata;
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] mk_line(input logic [31:0] seed);
    logic [LINE_W-1:0] r;
    r = '0;
    for (int i = 0; i < BEATS; i++)
      r[BEAT_W*i +: BEAT_W] = {seed, (32'(i) * 32'h0101_0101) ^ 32'hA5A5_A5A5};
    return r;
  endfunction

  // Presents b_rd and returns in the b_dv cycle (b_rd already dropped).
  task automatic do_read(input logic [63:0] addr, input int max_cyc, output int lat);
    int  c0;
    bit  ok;
    b_addr = addr;
    b_rd   = 1'b1;
    c0     = cyc;
    ok     = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      tick();
      if (b_dv) begin
        ok = 1'b1;
        break;
      end
    end
    b_rd = 1'b0;
    lat  = cyc - c0;
    chk("read_timeout", 64'(ok), 64'd1);
  endtask

  // Pulses b_wr, then presents the line the following cycle.
  task automatic do_write(input logic [63:0] addr, input logic [LINE_W-1:0] data);
    b_addr = addr;
    b_wr   = 1'b1;
    tick();
    b_wr    = 1'b0;
    b_wdata = data;
    tick();
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("idle_timeout", 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int lat, r0, w0, d0;
    logic [LINE_W-1:0] pat;

    clr_n   = 1'b0;
    b_addr  = '0;
    b_rd    = 1'b0;
    b_wr    = 1'b0;
    b_wdata = '0;
    repeat (3) tick();

    chk("rst_busy",    64'(busy),    64'd0);
    chk("rst_b_dv",    64'(b_dv),    64'd0);
    chk("rst_m_rd",    64'(m_rd),    64'd0);
    chk("rst_m_wr",    64'(m_wr),    64'd0);
    chk("rst_m_addr",  m_addr,       64'd0);
    chk("rst_m_wdata", m_wdata,      64'd0);
    chk("rst_b_rdata", 64'(|b_rdata), 64'd0);
    chk("rst_wr_drop", 64'(wr_drop), 64'd0);
    clr_n = 1'b1;
    tick();

    // Read 0x1080 with single-cycle acks: beats 0x1080..0x10F8, b_dv at 17.
    rd_base = rd_beats; r0 = rd_n; d0 = dv_n;
    do_read(64'h1080, 100, lat);
    chk("rd1_latency", 64'(lat), 64'd17);
    tick();
    chk("rd1_beats", 64'(rd_n - r0), 64'd16);
    for (int i = 0; i < BEATS; i++) begin
      chk($sformatf("rd1_addr%0d", i), rd_log[r0+i], 64'h1080 + 64'(8*i));
      chk($sformatf("rd1_data%0d", i), b_rdata[BEAT_W*i +: BEAT_W], 64'(i));
    end
    chk("rd1_dv_once", 64'(dv_n - d0), 64'd1);
    chk("rd1_idle",    64'(busy),      64'd0);

    // Offset bits ignored; acks 3 cycles late -> 4 cycles per beat, b_dv at 65.
    ack_delay = 3;
    rd_base = rd_beats; r0 = rd_n; d0 = dv_n;
    do_read(64'h7F9A, 200, lat);
    chk("rd2_latency", 64'(lat), 64'd65);
    tick();
    chk("rd2_beats",   64'(rd_n - r0),  64'd16);
    chk("rd2_addr0",   rd_log[r0],      64'h7F80);
    chk("rd2_addr15",  rd_log[r0+15],   64'h7FF8);
    chk("rd2_data9",   b_rdata[BEAT_W*9 +: BEAT_W], 64'd9);
    chk("rd2_dv_once", 64'(dv_n - d0),  64'd1);
    chk("rd2_stable",  64'(unstable_n), 64'd0);
    ack_delay = 0;

    // Posted write of a line at 0x3000.
    pat = mk_line(32'h3000_C0DE);
    w0 = wr_n; d0 = dv_n;
    do_write(64'h3000, pat);
    wait_idle(100);
    chk("wr1_beats", 64'(wr_n - w0), 64'd16);
    for (int i = 0; i < BEATS; i += 5) begin
      chk($sformatf("wr1_addr%0d", i), wa_log[w0+i], 64'h3000 + 64'(8*i));
      chk($sformatf("wr1_data%0d", i), wd_log[w0+i], pat[BEAT_W*i +: BEAT_W]);
    end
    chk("wr1_addr15",  wa_log[w0+15],  64'h3078);
    chk("wr1_no_dv",   64'(dv_n - d0), 64'd0);
    chk("wr1_no_drop", 64'(wr_drop),   64'd0);

`ifdef LFC_RD_FWD_EN
    // Written line is answered from the write buffer without memory reads.
    pat = mk_line(32'h2000_BEEF);
    do_write(64'h2000, pat);
    wait_idle(100);
    r0 = rd_n;
    do_read(64'h2000, 20, lat);
    chk("fwd_latency", 64'(lat), 64'd1);
    tick();
    chk("fwd_no_mrd", 64'(rd_n - r0), 64'd0);
    for (int i = 0; i < BEATS; i += 3)
      chk($sformatf("fwd_data%0d", i), b_rdata[BEAT_W*i +: BEAT_W], pat[BEAT_W*i +: BEAT_W]);
    rd_base = rd_beats; r0 = rd_n;
    do_read(64'h2080, 100, lat);
    chk("fwd_miss_latency", 64'(lat), 64'd17);
    tick();
    chk("fwd_miss_beats", 64'(rd_n - r0), 64'd16);
    chk("fwd_miss_addr0", rd_log[r0],     64'h2080);
    chk("fwd_miss_data4", b_rdata[BEAT_W*4 +: BEAT_W], 64'd4);
`else
    // Without forwarding a read of the just-written line still goes to memory.
    rd_base = rd_beats; r0 = rd_n;
    do_read(64'h3000, 100, lat);
    chk("nofwd_latency", 64'(lat), 64'd17);
    tick();
    chk("nofwd_beats", 64'(rd_n - r0), 64'd16);
    chk("nofwd_data3", b_rdata[BEAT_W*3 +: BEAT_W], 64'd3);
`endif

    // b_wr in the RD_DONE cycle is accepted; a second b_wr mid-drain is dropped.
    pat = mk_line(32'h5000_F00D);
    rd_base = rd_beats; w0 = wr_n;
    do_read(64'h4000, 100, lat);
    chk("rdwr_latency", 64'(lat), 64'd17);
    b_addr = 64'h5000;
    b_wr   = 1'b1;
    tick();
    b_wr    = 1'b0;
    b_wdata = pat;
    chk("rdwr_busy",    64'(busy),    64'd1);
    chk("rdwr_no_drop", 64'(wr_drop), 64'd0);
    repeat (3) tick();
    b_addr = 64'h9000;
    b_wr   = 1'b1;
    tick();
    b_wr = 1'b0;
    chk("rdwr_drop_set", 64'(wr_drop), 64'd1);
    wait_idle(100);
    repeat (5) tick();
    chk("rdwr_beats",   64'(wr_n - w0), 64'd16);
    chk("rdwr_addr0",   wa_log[w0],     64'h5000);
    chk("rdwr_addr15",  wa_log[w0+15],  64'h5078);
    chk("rdwr_data7",   wd_log[w0+7],   pat[BEAT_W*7 +: BEAT_W]);
    chk("rdwr_idle",    64'(busy),      64'd0);
    chk("rdwr_drop_sticky", 64'(wr_drop), 64'd1);

    // Reset while beat 7 of a read is outstanding aborts the fill.
    rd_base = rd_beats; r0 = rd_n; d0 = dv_n;
    b_addr = 64'h6000;
    b_rd   = 1'b1;
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 50; i++) begin
        tick();
        if (rd_n - r0 >= 7) begin
          hit = 1'b1;
          break;
        end
      end
      chk("rst_mid_reach7", 64'(hit), 64'd1);
    end
    chk("rst_mid_busy_before", 64'(m_rd), 64'd1);
    clr_n = 1'b0;
    b_rd  = 1'b0;
    tick();
    chk("rst_mid_m_rd",    64'(m_rd),     64'd0);
    chk("rst_mid_b_dv",    64'(b_dv),     64'd0);
    chk("rst_mid_b_rdata", 64'(|b_rdata), 64'd0);
    chk("rst_mid_busy",    64'(busy),     64'd0);
    chk("rst_mid_m_addr",  m_addr,        64'd0);
    chk("rst_mid_drop_clr", 64'(wr_drop), 64'd0);
    clr_n = 1'b1;
    repeat (20) tick();
    chk("rst_mid_no_dv", 64'(dv_n - d0), 64'd0);
    chk("rst_mid_idle",  64'(busy),      64'd0);

    chk("never_rd_and_wr", 64'(both_n),     64'd0);
    chk("req_stable",      64'(unstable_n), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
